// File: rtl/uart_screen_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the UART screen loader:
//   - loader_state_t : frame FSM state encoding
//   - SYNC_BYTE_DEFAULT : frame start marker
//   - CLKS_PER_BIT_DEFAULT : UART bit period in pixel clocks (25 MHz / 115200)
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_AHI   = 3'd1,
        ST_ALO   = 3'd2,
        ST_LHI   = 3'd3,
        ST_LLO   = 3'd4,
        ST_DATA  = 3'd5,
        ST_CKSUM = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int CLK_HZ               = 25_000_000;
    localparam int BAUD                 = 115_200;
    localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;

endpackage

// File: rtl/uart_screen_loader_if.sv
// -----------------------------------------------------------------------------
// uart_screen_loader_if
// Display RAM write port.
//   write_en : one-cycle write strobe
//   waddr    : write address (ADDR_WIDTH)
//   wdata    : write data (DATA_WIDTH)
// master = loader side (drives), slave = RAM side (receives).
// -----------------------------------------------------------------------------
interface uart_screen_loader_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport master (output write_en, waddr, wdata);
    modport slave  (input  write_en, waddr, wdata);
endinterface

// File: rtl/uart_screen_loader_uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 2-FF input synchroniser.
//   clk        : pixel clock
//   reset      : synchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   byte_valid : one-cycle strobe at the stop-bit sample point, stop bit = 1
//   rx_byte    : received byte (valid with byte_valid)
//   frame_err  : one-cycle strobe at the stop-bit sample point, stop bit = 0
// A start bit that is no longer low at its midpoint is dropped silently.
// -----------------------------------------------------------------------------
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);
    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
        end
    end

    // Strobes are combinational at the sample point so the frame logic can
    // register the RAM write one clock after the stop bit is sampled.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        bit_next   = bit_reg;
        shift_next = shift_reg;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next = '0;
                if (rx_prev_reg && !rx_sync_reg) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync_reg, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    byte_valid = rx_sync_reg;
                    frame_err  = !rx_sync_reg;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_byte = shift_reg;

endmodule

// File: rtl/uart_screen_loader.sv
// -----------------------------------------------------------------------------
// uart_screen_loader
// Loads the display RAM from a host over UART. Frame:
//   SYNC_BYTE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN+1 payload bytes
// Each payload byte becomes one RAM write, one clock after its stop bit.
// Ports:
//   clk, reset : pixel clock, synchronous active-high reset
//   rx         : UART line
//   ram        : RAM write port (write_en / waddr / wdata), master side
//   busy       : frame in progress
//   done       : pulse when the frame completes
//   err        : pulse on framing error, timeout or checksum mismatch
// Optional: define UART_SCREEN_LOADER_CKSUM_EN to require a trailing XOR
// checksum byte after the payload.
// -----------------------------------------------------------------------------
module uart_screen_loader
    import loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int         ADDR_WIDTH   = 11,
    parameter int         DATA_WIDTH   = 8,
    parameter int         TIMEOUT_CLKS = 2_500_000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    uart_screen_loader_if.master ram,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int                 IDLE_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CLKS - 1);

    logic       byte_valid, frame_err;
    logic [7:0] rx_byte;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    loader_state_t         state_reg, state_next;
    logic [7:0]            ahi_reg, ahi_next, alo_reg, alo_next, lhi_reg, lhi_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next, remain_reg, remain_next;
    logic [IDLE_W-1:0]     idle_reg, idle_next;
    logic                  write_en_reg, write_en_next;
    logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  busy_reg, busy_next, done_reg, done_next, err_reg, err_next;
`ifdef UART_SCREEN_LOADER_CKSUM_EN
    logic [7:0]            cksum_reg, cksum_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_SYNC;
            ahi_reg      <= '0;
            alo_reg      <= '0;
            lhi_reg      <= '0;
            addr_reg     <= '0;
            remain_reg   <= '0;
            idle_reg     <= '0;
            write_en_reg <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
`ifdef UART_SCREEN_LOADER_CKSUM_EN
            cksum_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            ahi_reg      <= ahi_next;
            alo_reg      <= alo_next;
            lhi_reg      <= lhi_next;
            addr_reg     <= addr_next;
            remain_reg   <= remain_next;
            idle_reg     <= idle_next;
            write_en_reg <= write_en_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
`ifdef UART_SCREEN_LOADER_CKSUM_EN
            cksum_reg    <= cksum_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        ahi_next      = ahi_reg;
        alo_next      = alo_reg;
        lhi_next      = lhi_reg;
        addr_next     = addr_reg;
        remain_next   = remain_reg;
        write_en_next = 1'b0;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
`ifdef UART_SCREEN_LOADER_CKSUM_EN
        cksum_next    = cksum_reg;
`endif
        // Idle counter only runs inside a frame; any received byte restarts it,
        // which also makes a byte win over a coincident timeout.
        if (state_reg == ST_SYNC || byte_valid) begin
            idle_next = '0;
        end else begin
            idle_next = idle_reg + IDLE_W'(1);
        end

        if (frame_err) begin
            err_next   = 1'b1;
            state_next = ST_SYNC;
        end else if (byte_valid) begin
`ifdef UART_SCREEN_LOADER_CKSUM_EN
            cksum_next = cksum_reg ^ rx_byte;
`endif
            case (state_reg)
                ST_SYNC: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_next = ST_AHI;
`ifdef UART_SCREEN_LOADER_CKSUM_EN
                        // Running XOR is seeded with the sync byte itself.
                        cksum_next = SYNC_BYTE;
`endif
                    end
                end
                ST_AHI: begin
                    ahi_next   = rx_byte;
                    state_next = ST_ALO;
                end
                ST_ALO: begin
                    alo_next   = rx_byte;
                    state_next = ST_LHI;
                end
                ST_LHI: begin
                    lhi_next   = rx_byte;
                    state_next = ST_LLO;
                end
                ST_LLO: begin
                    addr_next   = ADDR_WIDTH'({ahi_reg, alo_reg});
                    remain_next = ADDR_WIDTH'({lhi_reg, rx_byte});
                    state_next  = ST_DATA;
                end
                ST_DATA: begin
                    write_en_next = 1'b1;
                    waddr_next    = addr_reg;
                    wdata_next    = DATA_WIDTH'(rx_byte);
                    if (remain_reg == '0) begin
`ifdef UART_SCREEN_LOADER_CKSUM_EN
                        state_next = ST_CKSUM;
`else
                        done_next  = 1'b1;
                        state_next = ST_SYNC;
`endif
                    end else begin
                        addr_next   = addr_reg + ADDR_WIDTH'(1);
                        remain_next = remain_reg - ADDR_WIDTH'(1);
                    end
                end
`ifdef UART_SCREEN_LOADER_CKSUM_EN
                ST_CKSUM: begin
                    done_next  = (rx_byte == cksum_reg);
                    err_next   = (rx_byte != cksum_reg);
                    state_next = ST_SYNC;
                end
`endif
                default: state_next = ST_SYNC;
            endcase
        end else if (state_reg != ST_SYNC && idle_reg == IDLE_LAST) begin
            err_next   = 1'b1;
            state_next = ST_SYNC;
        end

        busy_next = (state_next != ST_SYNC);
    end

    assign ram.write_en = write_en_reg;
    assign ram.waddr    = waddr_reg;
    assign ram.wdata    = wdata_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule
